logic_op_stage: RTL and testbench
=================================

LOGIC_OP_STAGE -- requirements
Module: logic_op_stage

Interface
REQ-001 Parameter: CNT_W, default 16, width of the completed-operation counter.
REQ-002 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  command present.
REQ-005 Port: in_ready  output  1  stage can accept a command.
REQ-006 Port: in_a  input  8  operand A.
REQ-007 Port: in_b  input  8  operand B.
REQ-008 Port: in_op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NOT A (B ignored).
REQ-009 Port: in_chain  input  1  when 1, the accumulator replaces in_a as operand A.
REQ-010 Port: out_valid  output  1  result present.
REQ-011 Port: out_ready  input  1  consumer accepts result.
REQ-012 Port: out_d  output  8  result.
REQ-013 Port: out_zero  output  1  out_d equals 0x00.
REQ-014 Port: out_parity  output  1  XOR of all out_d bits.
REQ-015 Port: op_count  output  CNT_W  count of results loaded into the output register.

Function
REQ-016 A command SHALL be accepted on a rising edge where in_valid and in_ready are both 1; the command is {in_a, in_b, in_op, in_chain}.
REQ-017 Accepted commands SHALL enter a 2-entry in-order FIFO; in_ready SHALL equal (FIFO occupancy < 2), registered, with no combinational path from out_ready.
REQ-018 The output register SHALL be "free" when out_valid is 0, or when out_valid and out_ready are both 1.
REQ-019 When the FIFO is non-empty and the output register is free, the FIFO head SHALL be popped and its result loaded into out_d on the same edge.
REQ-020 Latency: a command accepted at edge k into an empty FIFO with a free output register SHALL have out_valid = 1 after edge k+1.
REQ-021 Throughput: one command per cycle SHALL be sustained while out_ready is held 1.
REQ-022 Push and pop on the same edge SHALL leave occupancy unchanged; a push at occupancy 2 cannot occur because in_ready is 0.
REQ-023 out_valid SHALL hold, and out_d/out_zero/out_parity SHALL stay stable, until a handshake completes (out_valid and out_ready both 1).
REQ-024 The 8-bit accumulator SHALL load the result value every time the output register is loaded.
REQ-025 Operand A for a chained command SHALL be the accumulator value as of the edge on which that command executes, so back-to-back chained commands see each preceding result in order.
REQ-026 out_zero and out_parity SHALL be registered together with out_d.
REQ-027 op_count SHALL increment by 1 on every output-register load and SHALL saturate at all-ones.

Reset
REQ-028 While rst_n = 0: FIFO SHALL be emptied, in_ready = 1, out_valid = 0, out_d = 0x00, out_zero = 1, out_parity = 0, accumulator = 0x00, op_count = 0.
REQ-029 Assertion of reset mid-operation SHALL discard all buffered and presented results immediately, without waiting for a clock edge.
REQ-030 The first rising edge after rst_n deasserts SHALL be able to accept a command.

Structure
REQ-031 The opcode constants (AND, OR, XOR, NOTA) SHALL live in the shared package.
REQ-032 The 2-entry FIFO SHALL be a sub-module named lop_fifo2.
REQ-033 The combinational operation SHALL be the team's existing 8-bit logic unit (logicUnit), instantiated once and driven with s1 = op[1], s0 = op[0].

Verification
REQ-034 After reset, check in_ready = 1, out_valid = 0, out_zero = 1, op_count = 0.
REQ-035 Ops: A=0xF0, B=0x3C, with out_ready = 1 throughout:
  - AND -> 0x30
  - OR -> 0xFC
  - XOR -> 0xCC
  - NOTA -> 0x0F
  - each result has out_valid one edge after acceptance.
REQ-036 Chain: A=0xAA, B=0x0F OR -> 0xAF; then chain XOR B=0xFF -> 0x50; then chain NOTA -> 0xAF; check out_zero and out_parity each step.
REQ-037 Backpressure: hold out_ready = 0 and send 4 commands. Require:
  - in_ready drops after 3 accepts (1 output + 2 FIFO);
  - out_d stays stable;
  - releasing out_ready drains all results in order.
REQ-038 Reset mid-stream with 2 commands buffered: out_valid = 0 immediately; no stale result appears afterwards; op_count = 0.
REQ-039 Saturation: with CNT_W = 4, issue 20 commands; op_count holds at 0xF.

Source files
------------

// File: rtl/logic_op_stage_pkg.sv
// Shared types and opcode constants for the logic-op stage.
package logic_op_stage_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NOTA = 2'b11;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [1:0]        op;
        logic              chain;
    } cmd_t;

endpackage

// File: rtl/logicUnit.sv
// 8-bit combinational logic unit: {s1,s0} selects AND / OR / XOR / NOT A.
module logicUnit
    import logic_op_stage_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       s1,
    input  logic       s0,
    output logic [7:0] y
);

    // Operation select; B is ignored for NOT A.
    always_comb begin
        y = 8'h00;
        case ({s1, s0})
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOTA: y = ~a;
            default: y = 8'h00;
        endcase
    end

endmodule

// File: rtl/lop_fifo2.sv
// Two-entry in-order command FIFO with a registered ready flag.
module lop_fifo2
    import logic_op_stage_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  cmd_t wdata_i,
    input  logic pop_i,
    output cmd_t rdata_o,
    output logic empty_o,
    output logic ready_o
);

    cmd_t       mem_q [2];
    logic       wptr_q, rptr_q;
    logic [1:0] cnt_q, cnt_d;
    logic       ready_q;
    logic       push_ok, pop_ok;

    assign push_ok = push_i && ready_q;
    assign pop_ok  = pop_i && (cnt_q != 2'd0);

    // Next occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop_ok)
            cnt_d = cnt_q + 2'd1;
        else if (pop_ok && !push_ok)
            cnt_d = cnt_q - 2'd1;
    end

    // Storage, pointers and ready flag; ready is precomputed from next occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            cnt_q    <= 2'd0;
            ready_q  <= 1'b1;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= ~wptr_q;
            end
            if (pop_ok)
                rptr_q <= ~rptr_q;
            cnt_q   <= cnt_d;
            ready_q <= (cnt_d != 2'd2);
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign empty_o = (cnt_q == 2'd0);
    assign ready_o = ready_q;

endmodule

// File: rtl/logic_op_stage.sv
// Buffered logic-op stage: 2-deep command FIFO feeding a registered result
// with accumulator chaining, zero/parity flags and a saturating op counter.
module logic_op_stage
    import logic_op_stage_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [1:0]       in_op,
    input  logic             in_chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_d,
    output logic             out_zero,
    output logic             out_parity,
    output logic [CNT_W-1:0] op_count
);

    cmd_t             in_cmd, head;
    logic             push, pop, fifo_empty, out_free;
    logic [7:0]       op_a, res;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_d_q, acc_q;
    logic             out_zero_q, out_parity_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign in_cmd = '{a: in_a, b: in_b, op: in_op, chain: in_chain};
    assign push   = in_valid && in_ready;

    lop_fifo2 u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (in_cmd),
        .pop_i   (pop),
        .rdata_o (head),
        .empty_o (fifo_empty),
        .ready_o (in_ready)
    );

    assign out_free = !out_valid_q || out_ready;
    assign pop      = !fifo_empty && out_free;

    // Chained commands read the accumulator at the moment they execute.
    assign op_a = head.chain ? acc_q : head.a;

    logicUnit u_lu (
        .a  (op_a),
        .b  (head.b),
        .s1 (head.op[1]),
        .s0 (head.op[0]),
        .y  (res)
    );

    // Output-valid and saturating counter next state.
    always_comb begin
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        if (pop) begin
            out_valid_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}})
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Result register, flags and accumulator load together on every pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_d_q      <= 8'h00;
            out_zero_q   <= 1'b1;
            out_parity_q <= 1'b0;
            acc_q        <= 8'h00;
            cnt_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            if (pop) begin
                out_d_q      <= res;
                out_zero_q   <= (res == 8'h00);
                out_parity_q <= ^res;
                acc_q        <= res;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_d      = out_d_q;
    assign out_zero   = out_zero_q;
    assign out_parity = out_parity_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_logic_op_stage.sv
// Directed, table-driven bench for logic_op_stage.
module tb_logic_op_stage;
    import logic_op_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready, in_chain;
    logic [7:0]  in_a, in_b;
    logic [1:0]  in_op;
    logic        in_ready, out_valid, out_zero, out_parity;
    logic [7:0]  out_d;
    logic [15:0] op_count;
    logic        in_ready4, out_valid4, out_zero4, out_parity4;
    logic [7:0]  out_d4;
    logic [3:0]  op_count4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic_op_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_chain(in_chain),
        .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d),
        .out_zero(out_zero), .out_parity(out_parity), .op_count(op_count)
    );

    logic_op_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_chain(in_chain),
        .out_valid(out_valid4), .out_ready(out_ready), .out_d(out_d4),
        .out_zero(out_zero4), .out_parity(out_parity4), .op_count(op_count4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic       chain;
        logic [7:0] exp_d;
        logic       exp_z;
        logic       exp_p;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic ch);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_chain = ch;
    endtask

    initial begin
        logic [7:0] got [$];
        logic       stale;
        int         budget;

        vecs[0] = '{8'hF0, 8'h3C, OP_AND,  1'b0, 8'h30, 1'b0, 1'b0};
        vecs[1] = '{8'hF0, 8'h3C, OP_OR,   1'b0, 8'hFC, 1'b0, 1'b0};
        vecs[2] = '{8'hF0, 8'h3C, OP_XOR,  1'b0, 8'hCC, 1'b0, 1'b0};
        vecs[3] = '{8'hF0, 8'h3C, OP_NOTA, 1'b0, 8'h0F, 1'b0, 1'b0};
        vecs[4] = '{8'h07, 8'h01, OP_AND,  1'b0, 8'h01, 1'b0, 1'b1};
        vecs[5] = '{8'h0F, 8'hF0, OP_AND,  1'b0, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'hFF, 8'h83, OP_OR,   1'b1, 8'h83, 1'b0, 1'b1};
        vecs[7] = '{8'hFF, 8'h83, OP_XOR,  1'b1, 8'h00, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = 8'h00; in_b = 8'h00; in_op = 2'b00; in_chain = 1'b0;
        step(); step();
        chk("rst_in_ready",  {31'd0, in_ready},  1);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_zero",  {31'd0, out_zero},  1);
        chk("rst_parity",    {31'd0, out_parity}, 0);
        chk("rst_op_count",  {16'd0, op_count},  0);
        chk("rst_op_count4", {28'd0, op_count4}, 0);
        rst_n = 1'b1;

        // Single commands, exact one-edge latency, chaining through the accumulator.
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 1);
            drive(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].chain);
            step();
            in_valid = 1'b0;
            chk($sformatf("v%0d_not_early", i), {31'd0, out_valid}, 0);
            step();
            chk($sformatf("v%0d_valid", i),  {31'd0, out_valid}, 1);
            chk($sformatf("v%0d_d", i),      {24'd0, out_d}, {24'd0, vecs[i].exp_d});
            chk($sformatf("v%0d_zero", i),   {31'd0, out_zero}, {31'd0, vecs[i].exp_z});
            chk($sformatf("v%0d_parity", i), {31'd0, out_parity}, {31'd0, vecs[i].exp_p});
        end
        chk("count_after_table", {16'd0, op_count}, 8);

        // Back-to-back chained commands at full throughput.
        step();
        drive(8'hAA, 8'h0F, OP_OR, 1'b0);   step();
        drive(8'h00, 8'hFF, OP_XOR, 1'b1);  step();
        chk("b2b_d0", {24'd0, out_d}, 32'hAF);
        chk("b2b_p0", {31'd0, out_parity}, 0);
        drive(8'h00, 8'h00, OP_NOTA, 1'b1); step();
        in_valid = 1'b0;
        chk("b2b_d1", {24'd0, out_d}, 32'h50);
        chk("b2b_z1", {31'd0, out_zero}, 0);
        chk("b2b_rdy", {31'd0, in_ready}, 1);
        step();
        chk("b2b_d2", {24'd0, out_d}, 32'hAF);
        chk("b2b_v2", {31'd0, out_valid}, 1);
        step();
        chk("b2b_drained", {31'd0, out_valid}, 0);

        // Backpressure: three accepts fill output + FIFO, then the rest waits.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_rdy%0d", i), {31'd0, in_ready}, 1);
            drive(8'(i + 1), 8'h00, OP_OR, 1'b0);
            step();
        end
        chk("bp_rdy_drop", {31'd0, in_ready}, 0);
        drive(8'h04, 8'h00, OP_OR, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("bp_hold_rdy%0d", i), {31'd0, in_ready}, 0);
            chk($sformatf("bp_hold_d%0d", i), {24'd0, out_d}, 1);
            chk($sformatf("bp_hold_v%0d", i), {31'd0, out_valid}, 1);
        end
        out_ready = 1'b1;
        budget = 0;
        while (got.size() < 4 && budget < 20) begin
            logic took;
            took = in_valid && in_ready;
            if (out_valid && out_ready) got.push_back(out_d);
            step();
            if (took) in_valid = 1'b0;
            budget++;
        end
        chk("bp_drain_count", got.size(), 4);
        for (int i = 0; i < got.size(); i++)
            chk($sformatf("bp_order%0d", i), {24'd0, got[i]}, i + 1);
        step();

        // Reset mid-stream with results buffered.
        out_ready = 1'b0;
        drive(8'h11, 8'h00, OP_OR, 1'b0); step();
        drive(8'h22, 8'h00, OP_OR, 1'b0); step();
        drive(8'h33, 8'h00, OP_OR, 1'b0); step();
        in_valid = 1'b0;
        chk("mid_pre_valid", {31'd0, out_valid}, 1);
        chk("mid_pre_full", {31'd0, in_ready}, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 0);
        chk("mid_rst_ready", {31'd0, in_ready}, 1);
        chk("mid_rst_count", {16'd0, op_count}, 0);
        chk("mid_rst_zero",  {31'd0, out_zero}, 1);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid) stale = 1'b1;
        end
        chk("mid_no_stale", {31'd0, stale}, 0);

        // Command on the first edge after a fresh deassertion.
        rst_n = 1'b0; step(); rst_n = 1'b1;
        drive(8'h5A, 8'hFF, OP_AND, 1'b0); step();
        in_valid = 1'b0; step();
        chk("post_rst_d", {24'd0, out_d}, 32'h5A);
        chk("post_rst_cnt", {16'd0, op_count}, 1);
        step();

        // Saturation of the narrow counter.
        drive(8'h01, 8'h01, OP_AND, 1'b0);
        for (int i = 0; i < 20; i++) step();
        in_valid = 1'b0;
        step(); step(); step();
        chk("sat_count4", {28'd0, op_count4}, 32'hF);
        chk("sat_count16", {16'd0, op_count}, 21);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
